instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch front end. It is the initiator side of the synchronous instruction ROM interface.
- Drives a word address to the ROM every cycle and consumes the ROM data returned one clock later.
- Tracks which returned words are wanted and buffers them in a 2-entry skid FIFO.
- Presents {pc, instruction} to the decoder over a valid/ready handshake; supports branch redirects and flags misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- ROM_WORDS, 128, number of 32-bit words in the ROM; a word index >= ROM_WORDS is out of range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rom_addr  out  32  word address to ROM, = {2'b00, pc_q[31:2]}; registered.
- rom_data  in  32  ROM read data; valid the cycle after the matching rom_addr.
- redirect_valid  in  1  flush pipeline and refetch from redirect_pc.
- redirect_pc  in  32  redirect target, byte address.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder accepts head this cycle.
- instr  out  32  instruction word at FIFO head.
- instr_pc  out  32  byte address of instr.
- fault  out  1  fetch halted on a bad address; sticky until redirect or reset.
- fault_pc  out  32  offending byte address.

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC, so rom_addr=RESET_PC>>2.
  - FIFO empty; instr_valid=0; instr=0; instr_pc=0.
  - inflight_v=0; fault=0; fault_pc=0; state=RUN.
- States:
  - RUN: normal fetching.
  - FAULT: no issue, no push; the FIFO still drains to the decoder.
- Issue, evaluated in RUN each cycle with no redirect. Define pop = instr_valid & instr_ready.
  - If count + inflight_v - pop < 2 and pc_q[31:2] < ROM_WORDS: issue. Set inflight_v=1, inflight_pc=pc_q, pc_q += 4.
  - If pc_q[31:2] >= ROM_WORDS: go to FAULT, fault=1, fault_pc=pc_q, no issue.
  - Otherwise: inflight_v=0 and pc_q holds.
- Return path:
  - When inflight_v=1, push {inflight_pc, rom_data} into the FIFO at the next edge.
  - The credit rule guarantees the FIFO never overflows; a push to a full FIFO is a bench assertion failure.
- Latency: an issue in cycle t gives instr_valid in cycle t+2.
- Throughput: 1 instruction/cycle with instr_ready held high.
- FIFO rules:
  - Simultaneous push and pop is legal at any occupancy 0..2.
  - instr, instr_pc and instr_valid come from registers.
  - Head data is stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, all states):
  - Clear FIFO and inflight_v; a ROM word arriving the next cycle is discarded.
  - Clear fault. No issue in the redirect cycle.
  - If redirect_pc[1:0]==0: pc_q=redirect_pc, state=RUN.
  - Else: state=FAULT, fault=1, fault_pc=redirect_pc.
  - Redirect in cycle t gives the target's instr_valid in cycle t+3.
  - pop is ignored in the redirect cycle.
- pc wrap: pc_q+4 wraps modulo 2^32; the range check catches it in practice.
- rst_n asserted mid-stream: immediate return to reset values; pending ROM data is ignored because inflight_v=0.

Test Plan:
- ROM model word i = 32'hA000_0000+i; reset release, instr_ready=1. Required:
  - instr_valid rises exactly 2 cycles after the first RUN cycle.
  - instr/instr_pc = A0000000/0, A0000001/4, A0000002/8… one per cycle.
- Steady stream, instr_ready=0 for 5 cycles then 1. Required:
  - Head held stable during the stall.
  - No word lost or duplicated; sequence resumes contiguously.
  - FIFO never exceeds 2 entries.
- Redirect to 32'h40 while FIFO is full and a fetch is in flight. Required:
  - Old entries gone the next cycle.
  - First valid is instr_pc=32'h40, instr=A0000010, 3 cycles after the redirect.
- Redirect to 32'h42. Required:
  - fault=1, fault_pc=32'h42, instr_valid=0 thereafter.
  - A later redirect to 32'h0 clears fault and resumes from A0000000.
- Redirect to 32'h1F8 (word 126), ROM_WORDS=128. Required:
  - Words 126 and 127 delivered.
  - Then fault=1, fault_pc=32'h200; both entries still drain before idle.
- Assert rst_n=0 mid-stream for 1 cycle. Required:
  - instr_valid drops asynchronously.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: drives word addresses to a synchronous ROM, tracks the
// one outstanding read, and buffers returned words in a 2-entry skid FIFO toward the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(ROM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic        inflight_v;
    logic [31:0] inflight_pc;
    logic        head_v, tail_v;
    logic [31:0] head_data, head_pc, tail_data, tail_pc;
    logic        fault_q;
    logic [31:0] fault_pc_q;

    logic        pop, push, in_range, credit_ok, issue, range_fault;
    logic [1:0]  occupancy;

    // A read may issue only if its word is guaranteed a FIFO slot when it returns.
    always_comb begin
        pop       = head_v & instr_ready & ~redirect_valid;
        push      = inflight_v & ~redirect_valid;
        in_range  = pc_q[31:2] < WORD_LIMIT;
        occupancy = 2'(head_v) + 2'(tail_v) + 2'(inflight_v);
        credit_ok = {1'b0, occupancy} < (3'd2 + {2'b00, pop});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        range_fault = 1'b0;
        if (redirect_valid) begin
            state_d = (redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
        end else if (state_q == RUN) begin
            if (!in_range) begin
                state_d     = FAULT;
                range_fault = 1'b1;
            end else if (credit_ok) begin
                issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= 32'h0;
            fault_q     <= 1'b0;
            fault_pc_q  <= 32'h0;
        end else if (redirect_valid) begin
            inflight_v <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc_q    <= redirect_pc;
                fault_q <= 1'b0;
            end else begin
                fault_q    <= 1'b1;
                fault_pc_q <= redirect_pc;
            end
        end else begin
            inflight_v <= issue;
            if (issue) begin
                inflight_pc <= pc_q;
                pc_q        <= pc_q + 32'd4;
            end
            if (range_fault) begin
                fault_q    <= 1'b1;
                fault_pc_q <= pc_q;
            end
        end
    end

    // The head entry drives the decoder outputs directly; the tail only ever shifts into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v    <= 1'b0;
            tail_v    <= 1'b0;
            head_data <= 32'h0;
            head_pc   <= 32'h0;
            tail_data <= 32'h0;
            tail_pc   <= 32'h0;
        end else if (redirect_valid) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (pop) begin
            if (tail_v) begin
                head_data <= tail_data;
                head_pc   <= tail_pc;
                if (push) begin
                    tail_data <= rom_data;
                    tail_pc   <= inflight_pc;
                end else begin
                    tail_v <= 1'b0;
                end
            end else if (push) begin
                head_data <= rom_data;
                head_pc   <= inflight_pc;
            end else begin
                head_v <= 1'b0;
            end
        end else if (push) begin
            if (!head_v) begin
                head_data <= rom_data;
                head_pc   <= inflight_pc;
                head_v    <= 1'b1;
            end else begin
                tail_data <= rom_data;
                tail_pc   <= inflight_pc;
                tail_v    <= 1'b1;
            end
        end
    end

    assign rom_addr    = {2'b00, pc_q[31:2]};
    assign instr_valid = head_v;
    assign instr       = head_data;
    assign instr_pc    = head_pc;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized ready/redirect
// run checked against a stream model (word i of the ROM holds A0000000+i).
module tb_instr_fetch;

    localparam int          ROM_WORDS = 128;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] LIMIT     = 32'(ROM_WORDS * 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_pc;

    instr_fetch #(.RESET_PC(RESET_PC), .ROM_WORDS(ROM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= 32'hA000_0000 + rom_addr;

    function automatic logic [31:0] rom_word(input logic [31:0] byte_pc);
        return 32'hA000_0000 + (byte_pc >> 2);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        tests_run++;
        if (instr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
        tests_run++;
        if (instr_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        tests_run++;
        if (fault_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_fault_pc: got %h expected 0", fault_pc); end
        tests_run++;
        if (rom_addr !== (RESET_PC >> 2)) begin tests_failed++; $display("[TB] FAIL reset_rom_addr: got %h expected %h", rom_addr, RESET_PC >> 2); end
    endtask

    // Releases reset and expects the first word two cycles after the first RUN cycle.
    task automatic test_startup(input string tag);
        @(negedge clk); rst_n = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_early_valid: got %b expected 0", tag, instr_valid); end
        exp_pc = RESET_PC;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL %s_stream[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         tag, i, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 4;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); instr_ready = 1'b0;
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); instr_ready = 1'b1;
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL stall_resume[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 4;
        end
    endtask

    task automatic test_redirect_full();
        @(negedge clk); instr_ready = 1'b0;
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); redirect_valid = 1'b0;
            tests_run++;
            if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redirect_flush[t+%0d]: got v=%b expected 0", i, instr_valid); end
        end
        exp_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL redirect_stream[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 4;
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h42;
        @(negedge clk); redirect_valid = 1'b0;
        tests_run++;
        if (fault !== 1'b1 || fault_pc !== 32'h42) begin tests_failed++; $display("[TB] FAIL misaligned_fault: got f=%b pc=%h expected f=1 pc=00000042", fault, fault_pc); end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (instr_valid !== 1'b0 || fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL misaligned_idle[%0d]: got v=%b f=%b expected v=0 f=1", i, instr_valid, fault); end
            @(negedge clk);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk); redirect_valid = 1'b0;
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL misaligned_clear: got f=%b expected 0", fault); end
        @(negedge clk);
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL misaligned_resume[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 4;
        end
    endtask

    task automatic test_range_end();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h1F8; instr_ready = 1'b0;
        @(negedge clk); redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h1F8) begin tests_failed++; $display("[TB] FAIL range_first: got v=%b pc=%h expected v=1 pc=000001f8", instr_valid, instr_pc); end
        @(negedge clk);
        tests_run++;
        if (fault !== 1'b1 || fault_pc !== 32'h200) begin tests_failed++; $display("[TB] FAIL range_fault: got f=%b pc=%h expected f=1 pc=00000200", fault, fault_pc); end
        exp_pc = 32'h1F8;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); instr_ready = 1'b1;
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL range_drain[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 4;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b0 || fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL range_idle[%0d]: got v=%b f=%b expected v=0 f=1", i, instr_valid, fault); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
        @(negedge clk); redirect_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc[31:8] !== 24'h000001) begin tests_failed++; $display("[TB] FAIL prereset_stream: got v=%b pc=%h expected v=1 pc=000001xx", instr_valid, instr_pc); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_valid: got %b expected 0", instr_valid); end
        tests_run++;
        if (rom_addr !== (RESET_PC >> 2)) begin tests_failed++; $display("[TB] FAIL async_rom_addr: got %h expected %h", rom_addr, RESET_PC >> 2); end
        test_startup("restart");
    endtask

    // Random ready/redirect traffic; the model only tracks the next byte address owed to the decoder.
    task automatic test_random();
        int   since = 0;
        int   word;
        logic do_redir;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            instr_ready    = ($urandom_range(0, 9) < 7);
            do_redir       = (cyc == 0) || ($urandom_range(0, 99) < 4);
            redirect_valid = do_redir;
            if (do_redir) begin
                word        = ($urandom_range(0, 1) == 1) ? int'($urandom_range(118, 127)) : int'($urandom_range(0, 127));
                redirect_pc = 32'(word) << 2;
            end
            if (since == 1 || since == 2) begin
                tests_run++;
                if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_blackout[%0d]: got v=%b expected 0", cyc, instr_valid); end
            end else if (since >= 3) begin
                if (exp_pc < LIMIT) begin
                    tests_run++;
                    if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_head[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                                 cyc, instr_valid, instr_pc, instr, exp_pc, rom_word(exp_pc));
                    end
                end else begin
                    tests_run++;
                    if (instr_valid !== 1'b0 || fault !== 1'b1 || fault_pc !== LIMIT) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_end[%0d]: got v=%b f=%b fpc=%h expected v=0 f=1 fpc=%h",
                                 cyc, instr_valid, fault, fault_pc, LIMIT);
                    end
                end
                if (exp_pc + 32'd8 < LIMIT) begin
                    tests_run++;
                    if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_nofault[%0d]: got f=%b expected 0", cyc, fault); end
                end
            end
            if (do_redir) begin
                exp_pc = redirect_pc;
                since  = 1;
            end else begin
                if (since >= 3 && instr_valid === 1'b1 && instr_ready) exp_pc += 4;
                if (since != 0) since++;
            end
        end
        @(negedge clk); redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_startup("startup");
        test_stall();
        test_redirect_full();
        test_misaligned();
        test_range_end();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
